rc4_decrypt_core: RTL and testbench

- Consumer side of the shuffled S-array: runs after the key-schedule shuffle has written S[0..255] into the working RAM.
- Executes the RC4 keystream generation (PRGA) with the swap-per-byte read/modify/write on S.
- XORs each keystream byte with the encrypted message ROM and writes plaintext to the decrypted-message RAM.
- Reports success or failure on a lowercase/space character check; a top-level key-search controller uses that report to decide whether to try the next key.

---
 rtl/rc4_decrypt_core.sv | 211 +++++++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_core.sv
// rc4_decrypt_core: RC4 keystream generation over a pre-shuffled S-RAM, decrypting the
// message ROM into the output RAM and flagging any byte outside [a-z] and space.
module rc4_decrypt_core #(
  parameter int MSG_LEN    = 32,
  parameter int ADDR_W_MSG = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [7:0]            s_address,
  output logic [7:0]            s_data,
  output logic                  s_wren,
  input  logic [7:0]            s_q,
  output logic [ADDR_W_MSG-1:0] rom_address,
  input  logic [7:0]            rom_q,
  output logic [ADDR_W_MSG-1:0] ram_address,
  output logic [7:0]            ram_data,
  output logic                  ram_wren,
  output logic                  finish,
  output logic                  msg_bad
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_INC_I, ST_RD_SI, ST_WAIT_SI, ST_LATCH_SI, ST_RD_SJ, ST_WAIT_SJ,
    ST_LATCH_SJ, ST_WR_SI, ST_WR_SJ, ST_RD_F, ST_WAIT_F, ST_LATCH_F, ST_WR_OUT, ST_DONE
  } state_t;

  localparam logic [ADDR_W_MSG-1:0] LAST_K = ADDR_W_MSG'(MSG_LEN - 1);

  function automatic logic is_text_char(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_i, r_j, r_si, r_sj, r_enc, r_out;
  logic [7:0]            w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt, w_enc_nxt, w_out_nxt;
  logic [ADDR_W_MSG-1:0] r_k, w_k_nxt;
  logic [7:0]            r_s_address, r_s_data, w_s_address_nxt, w_s_data_nxt;
  logic                  r_s_wren, w_s_wren_nxt;
  logic [ADDR_W_MSG-1:0] r_rom_address, w_rom_address_nxt;
  logic [ADDR_W_MSG-1:0] r_ram_address, w_ram_address_nxt;
  logic [7:0]            r_ram_data, w_ram_data_nxt;
  logic                  r_ram_wren, w_ram_wren_nxt;
  logic                  r_finish, w_finish_nxt;
  logic                  r_msg_bad, w_msg_bad_nxt;
  logic [7:0]            w_plain;

  assign w_plain = s_q ^ r_enc;

  // Next-state and next-output decode; outputs are registered so they appear in the state named
  always_comb begin
    w_state_nxt       = r_state;
    w_i_nxt           = r_i;
    w_j_nxt           = r_j;
    w_k_nxt           = r_k;
    w_si_nxt          = r_si;
    w_sj_nxt          = r_sj;
    w_enc_nxt         = r_enc;
    w_out_nxt         = r_out;
    w_s_address_nxt   = 8'h00;
    w_s_data_nxt      = 8'h00;
    w_s_wren_nxt      = 1'b0;
    w_rom_address_nxt = '0;
    w_ram_address_nxt = '0;
    w_ram_data_nxt    = 8'h00;
    w_ram_wren_nxt    = 1'b0;
    w_finish_nxt      = 1'b0;
    w_msg_bad_nxt     = r_msg_bad;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_INC_I;
          w_msg_bad_nxt = 1'b0;
          w_i_nxt       = 8'h00;
          w_j_nxt       = 8'h00;
          w_k_nxt       = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INC_I: begin
        w_i_nxt           = r_i + 8'd1;
        w_state_nxt       = ST_RD_SI;
        w_s_address_nxt   = r_i + 8'd1;
        w_rom_address_nxt = r_k;
      end
      ST_RD_SI: begin
        w_state_nxt       = ST_WAIT_SI;
        w_s_address_nxt   = r_i;
        w_rom_address_nxt = r_k;
      end
      ST_WAIT_SI: w_state_nxt = ST_LATCH_SI;
      ST_LATCH_SI: begin
        w_si_nxt        = s_q;
        w_j_nxt         = r_j + s_q;
        w_enc_nxt       = rom_q;
        w_state_nxt     = ST_RD_SJ;
        w_s_address_nxt = r_j + s_q;
      end
      ST_RD_SJ: begin
        w_state_nxt     = ST_WAIT_SJ;
        w_s_address_nxt = r_j;
      end
      ST_WAIT_SJ: w_state_nxt = ST_LATCH_SJ;
      ST_LATCH_SJ: begin
        w_sj_nxt        = s_q;
        w_state_nxt     = ST_WR_SI;
        w_s_address_nxt = r_i;
        w_s_data_nxt    = s_q;
        w_s_wren_nxt    = 1'b1;
      end
      ST_WR_SI: begin
        w_state_nxt     = ST_WR_SJ;
        w_s_address_nxt = r_j;
        w_s_data_nxt    = r_si;
        w_s_wren_nxt    = 1'b1;
      end
      ST_WR_SJ: begin
        w_state_nxt     = ST_RD_F;
        w_s_address_nxt = r_si + r_sj;
      end
      ST_RD_F: begin
        w_state_nxt     = ST_WAIT_F;
        w_s_address_nxt = r_si + r_sj;
      end
      ST_WAIT_F: w_state_nxt = ST_LATCH_F;
      ST_LATCH_F: begin
        w_out_nxt         = w_plain;
        w_state_nxt       = ST_WR_OUT;
        w_ram_address_nxt = r_k;
        w_ram_data_nxt    = w_plain;
        w_ram_wren_nxt    = 1'b1;
      end
      ST_WR_OUT: begin
        if (!is_text_char(r_out)) begin
          w_msg_bad_nxt = 1'b1;
          w_finish_nxt  = 1'b1;
          w_state_nxt   = ST_DONE;
        end else if (r_k == LAST_K) begin
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_k_nxt     = r_k + {{(ADDR_W_MSG-1){1'b0}}, 1'b1};
          w_state_nxt = ST_INC_I;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_finish_nxt = 1'b1;
          w_state_nxt  = ST_DONE;
        end else begin
          w_finish_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_i           <= 8'h00;
      r_j           <= 8'h00;
      r_k           <= '0;
      r_si          <= 8'h00;
      r_sj          <= 8'h00;
      r_enc         <= 8'h00;
      r_out         <= 8'h00;
      r_s_address   <= 8'h00;
      r_s_data      <= 8'h00;
      r_s_wren      <= 1'b0;
      r_rom_address <= '0;
      r_ram_address <= '0;
      r_ram_data    <= 8'h00;
      r_ram_wren    <= 1'b0;
      r_finish      <= 1'b0;
      r_msg_bad     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_k           <= w_k_nxt;
      r_si          <= w_si_nxt;
      r_sj          <= w_sj_nxt;
      r_enc         <= w_enc_nxt;
      r_out         <= w_out_nxt;
      r_s_address   <= w_s_address_nxt;
      r_s_data      <= w_s_data_nxt;
      r_s_wren      <= w_s_wren_nxt;
      r_rom_address <= w_rom_address_nxt;
      r_ram_address <= w_ram_address_nxt;
      r_ram_data    <= w_ram_data_nxt;
      r_ram_wren    <= w_ram_wren_nxt;
      r_finish      <= w_finish_nxt;
      r_msg_bad     <= w_msg_bad_nxt;
    end
  end

  assign s_address   = r_s_address;
  assign s_data      = r_s_data;
  assign s_wren      = r_s_wren;
  assign rom_address = r_rom_address;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
  assign finish      = r_finish;
  assign msg_bad     = r_msg_bad;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: synchronous memory models, a software RC4 reference model,
// directed vectors with literal expectations and a per-cycle RAM-write checker.
module tb_rc4_decrypt_core;

  localparam int MSG_LEN = 32;
  localparam int AW      = 5;

  logic          clk = 1'b0;
  logic          rst_n, start;
  logic [7:0]    s_address, s_data, s_q;
  logic          s_wren;
  logic [AW-1:0] rom_address, ram_address;
  logic [7:0]    rom_q, ram_data;
  logic          ram_wren, finish, msg_bad;

  logic [7:0] s_init  [256];
  logic [7:0] s_mem   [256];
  logic [7:0] rom_mem [MSG_LEN];
  logic [7:0] ram_mem [MSG_LEN];
  logic       do_load;

  logic [7:0] exp_q [$];
  logic [7:0] exp_s [256];
  logic       exp_bad;
  int         wr_idx;
  int         total = 0;
  int         bad   = 0;

  rc4_decrypt_core #(.MSG_LEN(MSG_LEN), .ADDR_W_MSG(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .finish(finish), .msg_bad(msg_bad)
  );

  always #5 clk = ~clk;

  // Synchronous memories: registered address, data valid after the edge
  always @(posedge clk) begin
    if (do_load) begin
      s_mem   <= s_init;
      ram_mem <= '{default: 8'hEE};
    end else begin
      if (s_wren)   s_mem[s_address]     <= s_data;
      if (ram_wren) ram_mem[ram_address] <= ram_data;
    end
    s_q   <= s_mem[s_address];
    rom_q <= rom_mem[rom_address];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference RC4 PRGA over s_init and rom_mem, stopping on the first non-text byte
  task automatic model();
    logic [7:0] s [256];
    logic [7:0] i, j, si, sj, p;
    s = s_init; i = 8'd0; j = 8'd0; exp_bad = 1'b0;
    exp_q.delete();
    for (int k = 0; k < MSG_LEN; k++) begin
      i = i + 8'd1; si = s[i]; j = j + si; sj = s[j];
      s[i] = sj; s[j] = si;
      p = s[8'(si + sj)] ^ rom_mem[k];
      exp_q.push_back(p);
      if (!(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) begin
        exp_bad = 1'b1;
        break;
      end
    end
    exp_s = s;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < MSG_LEN; x++) rom_mem[x] = 8'h00;
  endtask

  task automatic run_and_check(input string tag, input int len_lit, input logic bad_lit);
    int cnt, nmis;
    logic done;
    model();
    chk({tag, "_model_len"}, 64'(exp_q.size()), 64'(len_lit));
    chk({tag, "_model_bad"}, 64'(exp_bad), 64'(bad_lit));
    @(negedge clk) do_load = 1'b1;
    @(negedge clk) do_load = 1'b0;
    wr_idx = 0;
    start = 1'b1;
    @(posedge clk);
    cnt = 0; done = 1'b0;
    while (!done && cnt < 2000) begin
      @(posedge clk); cnt++;
      #1 if (finish) done = 1'b1;
    end
    chk({tag, "_finish_seen"}, 64'(done), 64'd1);
    chk({tag, "_cycles"}, 64'(cnt), 64'(13 * exp_q.size()));
    chk({tag, "_msg_bad"}, 64'(msg_bad), 64'(exp_bad));
    chk({tag, "_writes"}, 64'(wr_idx), 64'(exp_q.size()));
    nmis = 0;
    for (int k = 0; k < exp_q.size(); k++) if (ram_mem[k] !== exp_q[k]) nmis++;
    chk({tag, "_ram_bytes"}, 64'(nmis), 64'd0);
    if (exp_q.size() < MSG_LEN) chk({tag, "_ram_untouched"}, 64'(ram_mem[exp_q.size()]), 64'hEE);
    nmis = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) nmis++;
    chk({tag, "_s_final"}, 64'(nmis), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk({tag, "_finish_held"}, 64'(finish), 64'd1);
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    #1 chk({tag, "_finish_clear"}, 64'(finish), 64'd0);
    chk({tag, "_msg_bad_hold"}, 64'(msg_bad), 64'(exp_bad));
  endtask

  // Per-cycle check of every RAM write against the model, plus enable exclusivity
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ram_wren) begin
        if (wr_idx < exp_q.size()) begin
          chk("ram_wr_addr", 64'(ram_address), 64'(wr_idx));
          chk("ram_wr_data", 64'(ram_data), 64'(exp_q[wr_idx]));
        end else begin
          chk("ram_wr_extra", 64'(wr_idx), 64'(exp_q.size()));
        end
        wr_idx++;
      end
      if (s_wren || ram_wren) chk("wren_excl", 64'(s_wren & ram_wren), 64'd0);
    end
  end

  initial begin
    logic [8*MSG_LEN-1:0] pt;
    logic [7:0] key [3];
    logic [7:0] ks_s [256];
    logic [7:0] ji, ii, si, sj, tmp;
    int nmis, cnt;

    rst_n = 1'b0; start = 1'b0; do_load = 1'b0; wr_idx = 0;
    set_identity();
    repeat (2) @(posedge clk);
    #1 chk("reset_mem_outs", {s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren},
           64'd0);
    chk("reset_flags", {finish, msg_bad}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Identity S: keystream 02,05,07 -> "ab" then 0x00 aborts
    set_identity();
    rom_mem[0] = 8'h63; rom_mem[1] = 8'h67; rom_mem[2] = 8'h07;
    run_and_check("t1", 3, 1'b1);
    chk("t1_ram0", 64'(ram_mem[0]), 64'h61);
    chk("t1_ram1", 64'(ram_mem[1]), 64'h62);
    chk("t1_ram2", 64'(ram_mem[2]), 64'h00);
    chk("t1_s2", 64'(s_mem[2]), 64'h03);
    chk("t1_s3", 64'(s_mem[3]), 64'h05);
    chk("t1_s5", 64'(s_mem[5]), 64'h02);

    set_identity();
    rom_mem[0] = 8'h02;
    run_and_check("t2", 1, 1'b1);
    chk("t2_ram0", 64'(ram_mem[0]), 64'h00);

    set_identity();
    rom_mem[0] = 8'h22; rom_mem[1] = 8'h04;
    run_and_check("t3", 2, 1'b1);
    chk("t3_ram0_space", 64'(ram_mem[0]), 64'h20);
    chk("t3_ram1", 64'(ram_mem[1]), 64'h01);

    // S[0]=1, S[1]=0: j lands on 0, swap restores identity, f=S[1]=1
    set_identity();
    s_init[0] = 8'h01; s_init[1] = 8'h00;
    rom_mem[0] = 8'h60; rom_mem[1] = 8'h04;
    run_and_check("t4", 2, 1'b1);
    chk("t4_ram0", 64'(ram_mem[0]), 64'h61);
    chk("t4_s0", 64'(s_mem[0]), 64'h00);
    chk("t4_s1", 64'(s_mem[1]), 64'h01);

    // Full-length message over a real key schedule
    key[0] = 8'h1A; key[1] = 8'h2B; key[2] = 8'h3C;
    for (int x = 0; x < 256; x++) ks_s[x] = 8'(x);
    ji = 8'd0;
    for (int x = 0; x < 256; x++) begin
      ji = ji + ks_s[x] + key[x % 3];
      tmp = ks_s[x]; ks_s[x] = ks_s[ji]; ks_s[ji] = tmp;
    end
    s_init = ks_s;
    pt = "attack at dawn and hold the hill";
    ii = 8'd0; ji = 8'd0;
    for (int k = 0; k < MSG_LEN; k++) begin
      ii = ii + 8'd1; si = ks_s[ii]; ji = ji + si; sj = ks_s[ji];
      ks_s[ii] = sj; ks_s[ji] = si;
      rom_mem[k] = ks_s[8'(si + sj)] ^ pt[8*(MSG_LEN-1-k) +: 8];
    end
    run_and_check("t5", MSG_LEN, 1'b0);
    nmis = 0;
    for (int k = 0; k < MSG_LEN; k++) if (ram_mem[k] !== pt[8*(MSG_LEN-1-k) +: 8]) nmis++;
    chk("t5_plaintext", 64'(nmis), 64'd0);

    // Reset during the first WR_SI, then a fresh run
    set_identity();
    rom_mem[0] = 8'h22; rom_mem[1] = 8'h04;
    model();
    wr_idx = 0;
    @(negedge clk) start = 1'b1;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clk); cnt++;
      #1 if (s_wren) break;
    end
    chk("t6_reach_wr_si", 64'(s_wren), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_mem_outs", {s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren},
           64'd0);
    chk("t6_rst_flags", {finish, msg_bad}, 64'd0);
    @(negedge clk) begin start = 1'b0; rst_n = 1'b1; end
    @(posedge clk);
    #1 chk("t6_idle_finish", 64'(finish), 64'd0);
    run_and_check("t6", 2, 1'b1);
    chk("t6_ram0", 64'(ram_mem[0]), 64'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
